// File: rtl/trace_pkg.sv
// Shared types for the ALU trace buffer: controller states and trigger modes.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_READOUT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'd0,
        TRIG_EQUAL     = 2'd1,
        TRIG_MASKED    = 2'd2,
        TRIG_RESERVED  = 2'd3
    } trig_mode_t;

endpackage

// File: rtl/alu_trace_buffer_if.sv
// Readout stream of the trace buffer: valid/ready beats with a last marker.
interface alu_trace_buffer_if #(
    parameter int DATA_W = 32
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // Producer side (the trace buffer)
    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    // Consumer side
    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/trace_ram.sv
// Sample storage: one write port, one read port with a registered output.
module trace_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write when enabled; read data is always registered one cycle after the address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/alu_trace_buffer.sv
// Triggered trace capture of an observed ALU value, with oldest-first
// streaming readout of the stored window.
module alu_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic [1:0]             trig_mode,
    input  logic [DATA_W-1:0]      trig_value,
    input  logic [DATA_W-1:0]      trig_mask,
    input  logic                   sample_valid,
    input  logic [DATA_W-1:0]      sample_data,
    input  logic                   rd_start,
    alu_trace_buffer_if.master     rd,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] POST_TRIG_C = CW'(POST_TRIG);

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     load_ptr;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     start_idx;
    logic [CW-1:0]     post_cnt;
    logic [CW-1:0]     beat_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              hit;
    logic              load;

    function automatic logic trig_match(input logic [1:0]        mode,
                                        input logic [DATA_W-1:0] s,
                                        input logic [DATA_W-1:0] v,
                                        input logic [DATA_W-1:0] m);
        case (trig_mode_t'(mode))
            TRIG_IMMEDIATE: return 1'b1;
            TRIG_EQUAL:     return s == v;
            TRIG_MASKED:    return (s & m) == (v & m);
            default:        return 1'b0;
        endcase
    endfunction

    // A restart pulse takes priority over the sample arriving in the same cycle.
    assign wr_en = sample_valid && !arm && !reset &&
                   (state == ST_ARMED || state == ST_CAPTURE);
    assign hit   = trig_match(trig_mode, sample_data, trig_value, trig_mask);

    // Once the buffer has wrapped the oldest entry sits at the write pointer.
    assign start_idx = (count == DEPTH_C) ? wr_ptr : '0;

    // Load a new beat when the output register is empty or its beat is leaving.
    assign load = (state == ST_READOUT) &&
                  (!rd.out_valid || (rd.out_ready && !rd.out_last));

    // Address the RAM one cycle ahead so its registered output always holds the next beat.
    always_comb begin
        rd_addr = load_ptr;
        if (state == ST_DONE) begin
            rd_addr = start_idx;
        end else if (load) begin
            rd_addr = load_ptr + 1'b1;
        end
    end

    trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (sample_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Capture/readout controller with registered status and stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            count        <= '0;
            post_cnt     <= '0;
            load_ptr     <= '0;
            beat_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd.out_valid <= 1'b0;
            rd.out_last  <= 1'b0;
            rd.out_data  <= '0;
        end else if (arm && state != ST_READOUT) begin
            state    <= ST_ARMED;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (sample_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (count != DEPTH_C) begin
                            count <= count + 1'b1;
                        end
                        // The trigger sample itself is post-trigger sample 1.
                        if (state == ST_CAPTURE || hit) begin
                            post_cnt <= post_cnt + 1'b1;
                            if (post_cnt + 1'b1 == POST_TRIG_C) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_CAPTURE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_start) begin
                        state    <= ST_READOUT;
                        done     <= 1'b0;
                        load_ptr <= start_idx;
                        beat_cnt <= '0;
                    end
                end
                ST_READOUT: begin
                    if (load) begin
                        rd.out_data  <= rd_data;
                        rd.out_valid <= 1'b1;
                        rd.out_last  <= (beat_cnt + 1'b1 == count);
                        beat_cnt     <= beat_cnt + 1'b1;
                        load_ptr     <= load_ptr + 1'b1;
                    end else if (rd.out_valid && rd.out_ready) begin
                        state        <= ST_IDLE;
                        rd.out_valid <= 1'b0;
                        rd.out_last  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_trace_buffer.sv
// Randomised scoreboard bench for alu_trace_buffer with a queue-based reference model.
module tb_alu_trace_buffer;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic [1:0]        trig_mode = 2'd0;
    logic [DATA_W-1:0] trig_value = '0;
    logic [DATA_W-1:0] trig_mask = '0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              rd_start = 1'b0;
    logic              busy;
    logic              done;
    logic [4:0]        count;

    alu_trace_buffer_if #(.DATA_W(DATA_W)) rd_bus ();

    alu_trace_buffer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .trig_mode    (trig_mode),
        .trig_value   (trig_value),
        .trig_mask    (trig_mask),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .rd_start     (rd_start),
        .rd           (rd_bus),
        .busy         (busy),
        .done         (done),
        .count        (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of beats the readout must deliver, oldest first
    logic [DATA_W-1:0] exp_data_q[$];
    bit                exp_last_q[$];

    // Reference model: the samples stored since the last arm, trimmed to DEPTH
    logic [DATA_W-1:0] m_buf[$];
    int                m_total = 0;
    int                m_post  = 0;
    bit                m_cap   = 0;
    bit                m_done  = 0;
    bit                m_read  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_match(input logic [1:0] mode, input logic [DATA_W-1:0] s,
                                     input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] m);
        if (mode == 2'd0) return 1'b1;
        if (mode == 2'd1) return s == v;
        if (mode == 2'd2) return (s & m) == (v & m);
        return 1'b0;
    endfunction

    task automatic model_update(input bit a, input bit sv, input logic [DATA_W-1:0] sd, input bit rs);
        if (a && !m_read) begin
            m_buf.delete();
            m_total = 0;
            m_post  = 0;
            m_cap   = 1;
            m_done  = 0;
        end else if (m_cap) begin
            if (sv) begin
                m_buf.push_back(sd);
                if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
                m_total++;
                if (m_post > 0 || ref_match(trig_mode, sd, trig_value, trig_mask)) m_post++;
                if (m_post == POST_TRIG) begin
                    m_cap  = 0;
                    m_done = 1;
                end
            end
        end else if (m_done && rs) begin
            m_done = 0;
            m_read = 1;
            foreach (m_buf[i]) begin
                exp_data_q.push_back(m_buf[i]);
                exp_last_q.push_back(i == m_buf.size() - 1);
            end
        end
    endtask

    task automatic step(input bit a, input bit sv, input logic [DATA_W-1:0] sd,
                        input bit rs, input bit rdy);
        arm              = a;
        sample_valid     = sv;
        sample_data      = sd;
        rd_start         = rs;
        rd_bus.out_ready = rdy;
        @(posedge clk);
        model_update(a, sv, sd, rs);
        #1;
        check("count", 64'(count), 64'((m_total > DEPTH) ? DEPTH : m_total));
        check("busy", 64'(busy), 64'(m_cap));
        check("done", 64'(done), 64'(m_done));
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        arm              = 1'b0;
        sample_valid     = 1'b0;
        rd_start         = 1'b0;
        rd_bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_data_q.delete();
        exp_last_q.delete();
        m_buf.delete();
        m_total = 0;
        m_post  = 0;
        m_cap   = 0;
        m_done  = 0;
        m_read  = 0;
        check("rst_out_valid", 64'(rd_bus.out_valid), 64'(0));
        check("rst_out_last", 64'(rd_bus.out_last), 64'(0));
        check("rst_out_data", 64'(rd_bus.out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_count", 64'(count), 64'(0));
    endtask

    // ready_mode: 0 = always ready, 1 = repeating 1,0,0,1, other = random
    task automatic do_readout(input int ready_mode);
        int n = 0;
        bit rdy;
        step(0, 1'($urandom_range(0, 1)), $urandom, 1, 1);
        while ((exp_data_q.size() > 0 || rd_bus.out_valid) && n < 200) begin
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 4 == 0) || (n % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            // Stray arm/rd_start/samples while streaming must have no effect.
            step((exp_data_q.size() > 1) && ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), rdy);
            n++;
        end
        check("readout_finished_in_time", 64'(n < 200), 64'(1));
        m_read = 0;
        check("idle_after_readout_valid", 64'(rd_bus.out_valid), 64'(0));
    endtask

    task automatic capture_random(input int range_max);
        int n = 0;
        while (!m_done && n < 300) begin
            step(0, 1'($urandom_range(0, 9) < 6), DATA_W'($urandom_range(0, range_max)), 0, 0);
            n++;
        end
        check("capture_completed", 64'(done), 64'(1));
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    logic [DATA_W-1:0] prev_data;
    bit                prev_last;
    bit                stalled = 0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            stalled = 0;
        end else if (rd_bus.out_valid === 1'b1) begin
            if (stalled) begin
                check("stall_data", 64'(rd_bus.out_data), 64'(prev_data));
                check("stall_last", 64'(rd_bus.out_last), 64'(prev_last));
            end
            if (rd_bus.out_ready === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=%0h expected=no beat", rd_bus.out_data);
                end else begin
                    check("beat_data", 64'(rd_bus.out_data), 64'(exp_data_q.pop_front()));
                    check("beat_last", 64'(rd_bus.out_last), 64'(exp_last_q.pop_front()));
                end
                stalled = 0;
            end else begin
                stalled   = 1;
                prev_data = rd_bus.out_data;
                prev_last = rd_bus.out_last;
            end
        end else begin
            if (stalled) begin
                checks++;
                errors++;
                $display("FAIL valid_dropped_while_stalled actual=0 expected=1");
            end
            stalled = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Trigger on 5 after 0..3; eight post-trigger samples, twelve stored
        trig_mode = 2'd1; trig_value = 32'h5; trig_mask = '0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, DATA_W'((i < 4) ? i : i + 1), 0, 0);
        check("s1_count", 64'(count), 64'(12));
        check("s1_done", 64'(done), 64'(1));
        do_readout(0);

        // Wrap: 1..40 with trigger on 30, window 22..37
        trig_value = 32'd30;
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++) step(0, 1, DATA_W'(i), 0, 0);
        check("s2_count", 64'(count), 64'(16));
        check("s2_first_expected", 64'(m_buf[0]), 64'(22));
        do_readout(2);

        // Masked trigger with backpressure 1,0,0,1
        trig_mode = 2'd2; trig_mask = 32'hF0; trig_value = 32'h30;
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'h21, 0, 0);
        check("s3_not_triggered_busy", 64'(busy), 64'(1));
        step(0, 1, 32'h3A, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, DATA_W'(32'h40 + i), 0, 0);
        check("s3_count", 64'(count), 64'(9));
        do_readout(1);

        // Reset in the middle of a capture
        trig_mode = 2'd1; trig_value = 32'd3;
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, DATA_W'(i), 0, 0);
        do_reset();

        // Reset in the middle of a readout
        trig_mode = 2'd0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, $urandom, 0, 0);
        step(0, 0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        do_reset();

        // Re-arm during capture, then immediate trigger on the first valid sample
        trig_mode = 2'd0;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, DATA_W'(100 + i), 0, 0);
        step(1, 1, 32'hDEAD, 0, 0);
        check("s5_rearm_count", 64'(count), 64'(0));
        for (int i = 0; i < 8; i++) step(0, 1, DATA_W'(200 + i), 0, 0);
        check("s5_count", 64'(count), 64'(8));
        // arm and rd_start together in DONE: arm wins
        step(1, 0, 0, 1, 0);
        check("s5_arm_wins", 64'(busy), 64'(1));
        capture_random(255);
        do_readout(2);

        // Reserved mode never triggers; buffer keeps wrapping
        trig_mode = 2'd3;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, $urandom, 0, 1'($urandom_range(0, 1)));
        check("s6_busy", 64'(busy), 64'(1));
        check("s6_count", 64'(count), 64'(16));
        trig_mode = 2'd0;
        capture_random(255);
        do_readout(0);

        // Random sessions
        for (int s = 0; s < 6; s++) begin
            trig_mode  = 2'($urandom_range(0, 2));
            trig_value = DATA_W'($urandom_range(0, 7));
            trig_mask  = DATA_W'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) step(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 0);
            step(1, 0, 0, 0, 0);
            capture_random(7);
            repeat ($urandom_range(0, 3)) step(0, 1'($urandom_range(0, 1)), $urandom, 0, 0);
            do_readout(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_trace_buffer.md
ALU_TRACE_BUFFER -- requirements
Module: alu_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32, width of each captured sample.
REQ-002 Parameter DEPTH, default 16, buffer entries; power of 2, >= 4.
REQ-003 Parameter POST_TRIG, default 8, samples stored from the trigger sample onward; 1 <= POST_TRIG <= DEPTH.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 arm  in  1  single-cycle pulse; start a capture.
REQ-007 trig_mode  in  2  0 = immediate, 1 = sample == trig_value, 2 = (sample & trig_mask) == (trig_value & trig_mask), 3 = reserved (never triggers).
REQ-008 trig_value, trig_mask  in  DATA_W each  trigger compare operands, sampled every cycle.
REQ-009 sample_valid  in  1  sample_data is a valid sample this cycle.
REQ-010 sample_data  in  DATA_W  observed value (e.g. pipeline ALU_Out).
REQ-011 rd_start  in  1  single-cycle pulse; begin readout.
REQ-012 out_ready  in  1  consumer accepts the current beat.
REQ-013 out_valid  out  1  out_data holds a valid beat.
REQ-014 out_data  out  DATA_W  stored sample, oldest first.
REQ-015 out_last  out  1  final beat of the readout.
REQ-016 busy  out  1  high in ARMED or CAPTURE.
REQ-017 done  out  1  high in DONE.
REQ-018 count  out  $clog2(DEPTH)+1  number of valid entries stored, saturating at DEPTH.

Function
REQ-019 The FSM SHALL have states IDLE, ARMED, CAPTURE, DONE, READOUT.
REQ-020 IDLE or DONE + arm -> ARMED next cycle; write pointer, count and trigger flag cleared.
REQ-021 In ARMED and CAPTURE every sample_valid cycle SHALL write sample_data at wr_ptr, then wr_ptr+1 modulo DEPTH, count+1 saturating at DEPTH.
REQ-022 ARMED: a sample_valid cycle whose sample matches trig_mode SHALL be written and counted as post-trigger sample 1; if POST_TRIG = 1 -> DONE, else -> CAPTURE.
REQ-023 CAPTURE: after the POST_TRIG-th post-trigger sample is written -> DONE in the next cycle; no further writes.
REQ-024 arm in ARMED or CAPTURE SHALL restart the capture (same as REQ-020); arm in READOUT SHALL be ignored.
REQ-025 DONE + rd_start -> READOUT; rd_start in any other state SHALL be ignored; arm and rd_start together in DONE -> arm wins.
REQ-026 Readout start index = wr_ptr if count == DEPTH, else 0; exactly count beats in write order.
REQ-027 out_valid SHALL rise the cycle after entering READOUT; out_data/out_last SHALL be held stable while out_valid && !out_ready.
REQ-028 A beat is transferred when out_valid && out_ready; throughput one beat per cycle with out_ready held high.
REQ-029 out_last SHALL be high only on beat number count; after its transfer -> IDLE, out_valid low next cycle.
REQ-030 count retains its value in DONE and READOUT, cleared only by arm or reset.
REQ-031 sample_valid outside ARMED/CAPTURE SHALL not modify the buffer.

Reset
REQ-032 reset SHALL force IDLE, wr_ptr = 0, count = 0, out_valid = 0, out_last = 0, busy = 0, done = 0, out_data = 0, regardless of state, including mid-capture or mid-readout.
REQ-033 Buffer memory contents SHALL not require reset.

Structure
REQ-034 State enum and trig_mode encoding SHALL live in shared package trace_pkg.
REQ-035 Storage SHALL be sub-module trace_ram (1 write port, 1 registered read port, parametrised DATA_W/DEPTH).

Verification
REQ-036 DEPTH=16, POST_TRIG=8, mode 1, trig_value=0x5; samples 0..3 then 5 -> done after 8 post samples; readout 0,1,2,3,5,...; count=12, out_last on beat 12.
REQ-037 Wrap: samples 1..40, trigger on 30 (mode 1) -> count=16, readout 22..37, out_last on 37.
REQ-038 Mode 2, mask 0xF0, value 0x30, samples 0x21,0x3A -> trigger on 0x3A.
REQ-039 Backpressure: out_ready toggled 1,0,0,1 -> out_data unchanged while stalled, no beat lost or duplicated.
REQ-040 reset asserted mid-CAPTURE and mid-READOUT -> next cycle all outputs at reset values, state IDLE.
REQ-041 arm re-pulsed in CAPTURE -> count=0, new capture proceeds; mode 0 triggers on the first valid sample.
